// File: rtl/phy_pkg.sv
// Shared definitions for the PHY feed FIFO: default geometry, pointer width
// helper and the per-edge operation encoding.
package phy_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_POP   = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // One extra MSB so full and empty can be told apart when indices match.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/phy_fifo_mem.sv
// Word storage for phy_feed_fifo: synchronous write, combinational read,
// contents never reset.
module phy_fifo_mem
  import phy_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/phy_feed_fifo.sv
// Registered-output FIFO feeding a PHY data port, drained unless hold is high.
// Define PHY_FEED_FIFO_ERR_EN to build the sticky err_overflow detector.
module phy_feed_fifo
  import phy_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AFULL_THR = 6
) (
  input  logic                      clk_f,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      push,
  input  logic                      hold,
  output logic [DATA_W-1:0]         data_out,
  output logic                      valid_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [ptr_w(DEPTH)-1:0]   fill_level,
  output logic                      err_overflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic              pop, wr;
  logic              full_nxt, empty_nxt;
  fifo_op_e          op;
  logic [DATA_W-1:0] head;

  phy_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk_f),
    .we    (wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // Pop decision uses the registered empty flag, so a word written this edge
  // can never be drained before the next one.
  always_comb begin
    pop        = !empty && !hold;
    wr         = push && (!full || pop);
    op         = OP_NONE;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = fill_level;
    case ({pop, wr})
      2'b01:   op = OP_WRITE;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_NONE;
    endcase
    if (wr)  wr_ptr_nxt = wr_ptr + PW'(1);
    if (pop) rd_ptr_nxt = rd_ptr + PW'(1);
    unique case (op)
      OP_WRITE: level_nxt = fill_level + PW'(1);
      OP_POP:   level_nxt = fill_level - PW'(1);
      default:  level_nxt = fill_level;
    endcase
    full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_level  <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      fill_level  <= level_nxt;
      valid_out   <= pop;
      full        <= full_nxt;
      empty       <= empty_nxt;
      almost_full <= (level_nxt >= PW'(AFULL_THR));
      if (pop) data_out <= head;
    end
  end

`ifdef PHY_FEED_FIFO_ERR_EN
  logic drop;
  assign drop = push && full && !pop;

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset)    err_overflow <= 1'b0;
    else if (drop) err_overflow <= 1'b1;
  end
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: doc/phy_feed_fifo.md
PHY_FEED_FIFO -- requirements
Module: phy_feed_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width (matches PHY data_in).
REQ-002 SHALL have parameter DEPTH, default 8, number of stored words (power of two, ≥4).
REQ-003 SHALL have parameter AFULL_THR, default 6, fill level at or above which almost_full asserts.
REQ-004 SHALL have port clk_f, input, 1, sole clock (PHY word clock).
REQ-005 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port data_in, input, DATA_W, word to enqueue.
REQ-007 SHALL have port push, input, 1, enqueue request, sampled on rising clk_f.
REQ-008 SHALL have port hold, input, 1, when high suspends draining toward the PHY.
REQ-009 SHALL have port data_out, output, DATA_W, registered word driving PHY data_in.
REQ-010 SHALL have port valid_out, output, 1, registered qualifier driving PHY valid_in.
REQ-011 SHALL have ports full, empty, almost_full, outputs, 1 each, registered status.
REQ-012 SHALL have port fill_level, output, log2(DEPTH)+1, current stored word count.
REQ-013 SHALL have port err_overflow, output, 1, sticky overflow flag (see REQ-027).

Function
REQ-014 SHALL write data_in to storage at a rising clk_f edge when push=1 and (full=0 or a pop occurs on that same edge).
REQ-015 SHALL pop (read head, advance read pointer) at an edge when empty=0 and hold=0.
REQ-016 SHALL, on a pop edge, load data_out with head word and set valid_out=1; on a non-pop edge set valid_out=0 and hold data_out unchanged.
REQ-017 SHALL give latency of exactly one clk_f edge from storage write to valid_out: word written at edge N is popped no earlier than edge N+1 (no bypass when empty).
REQ-018 SHALL preserve strict FIFO order; no word duplicated or skipped.
REQ-019 SHALL use read/write pointers of log2(DEPTH)+1 bits; wrap at DEPTH with MSB toggle; full when indices equal and MSBs differ, empty when pointers equal.
REQ-020 SHALL update fill_level: +1 on write-only, −1 on pop-only, unchanged on simultaneous write and pop or neither.
REQ-021 SHALL, when full=1 and push=1 with a pop on the same edge, accept the push (level stays DEPTH).
REQ-022 SHALL, when full=1 and push=1 without pop, drop the word; pointers and storage unchanged.
REQ-023 SHALL assert almost_full when fill_level ≥ AFULL_THR, evaluated on the post-edge level.
REQ-024 SHALL treat hold as level-sensitive; hold rising mid-stream stops pops at that same edge, valid_out=0 next cycle.

Reset
REQ-025 SHALL, on reset=0 asynchronously: pointers=0, fill_level=0, data_out=0, valid_out=0, empty=1, full=0, almost_full=0, err_overflow=0; storage contents not reset.
REQ-026 SHALL discard any in-flight push coincident with reset assertion; first write accepted at first rising clk_f with reset=1.

Configuration
REQ-027 SHALL, with macro PHY_FEED_FIFO_ERR_EN defined, set err_overflow=1 on any REQ-022 drop and keep it until reset; without it, err_overflow SHALL be tied 0 and no detection logic synthesized.

Structure
REQ-028 SHALL take DATA_W default, DEPTH default and pointer-width function from shared package phy_pkg.
REQ-029 SHALL place storage in sub-module phy_fifo_mem (synchronous write, combinational read, no reset); control logic in phy_feed_fifo.

Verification
REQ-030 SHALL check: reset low, push 0xA5A5_0001 at edge 1, hold=0 -> valid_out=1, data_out=0xA5A5_0001 after edge 2, empty=1 after edge 2.
REQ-031 SHALL check: hold=1, push 8 words 0x0..0x7 -> full=1, almost_full=1 from level 6, fill_level=8; release hold -> 0x0..0x7 out on 8 consecutive cycles.
REQ-032 SHALL check: full, hold=1, push 0xDEAD_BEEF -> word dropped, fill_level=8, err_overflow=1 (macro defined) / 0 (macro undefined).
REQ-033 SHALL check: full, hold=0, push 0x1234_5678 same edge -> accepted, fill_level stays 8, 0x1234_5678 emerges 8th.
REQ-034 SHALL check: 20 words streamed through DEPTH=8 with random hold -> order preserved across pointer wrap, no valid_out while empty.
REQ-035 SHALL check: reset pulsed low mid-stream at fill_level=5, asynchronous to clk_f -> all outputs at REQ-025 values immediately, no stale word emitted after release.
